// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
// PS/2 device-to-host receiver with a clock glitch filter, start/parity/stop
// checking, a mid-frame inactivity timeout and a first-word-fall-through
// byte FIFO.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   ps2d, ps2c      raw PS/2 data and clock lines (asynchronous)
//   rx_en           allows a new frame to start (only looked at in IDLE)
//   rd_en           pops the FIFO head (ignored while empty)
//   dout            FIFO head, 8'h00 while empty
//   empty, full     FIFO status flags
//   count           number of bytes held in the FIFO
//   busy            receiver is inside a frame
//   parity_err      1-cycle pulse: odd-parity check failed
//   frame_err       1-cycle pulse: bad start bit, bad stop bit or timeout
//   overflow        1-cycle pulse: good byte dropped because the FIFO was full
module ps2_rx_fifo #(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2d,
    input  logic                          ps2c,
    input  logic                          rx_en,
    input  logic                          rd_en,
    output logic [7:0]                    dout,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          busy,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Clock filter and falling-edge detect
    // ------------------------------------------------------------------
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  fclk_q, fclk_d;
    logic                  fall;

    always_comb begin
        filt_d = {ps2c, filt_q[FILTER_LEN-1:1]};
        fclk_d = fclk_q;
        if (&filt_d) begin
            fclk_d = 1'b1;
        end else if (~|filt_d) begin
            fclk_d = 1'b0;
        end
        // Uses the next filter value so the edge is seen on the
        // FILTER_LEN-th consecutive low sample, not one cycle later.
        fall = fclk_q & ~fclk_d;
    end

    // ------------------------------------------------------------------
    // Frame FSM and timeout
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            par_q, par_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            parity_err_q, parity_err_d;
    logic            frame_err_q, frame_err_d;
    logic            overflow_q, overflow_d;
    logic            push;

    logic [CW-1:0]   count_q, count_d;
    logic            full_int;

    assign full_int = (count_q == CW'(FIFO_DEPTH));

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        overflow_d   = 1'b0;
        push         = 1'b0;

        if ((state_q == S_IDLE) || fall) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (fall && rx_en) begin
                    if (!ps2d) begin
                        bit_cnt_d = 3'd0;
                        state_d   = S_DATA;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (fall) begin
                    shreg_d   = {ps2d, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
                    par_d   = ps2d;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    state_d = S_IDLE;
                    if (!ps2d) begin
                        frame_err_d = 1'b1;
                    end else if (~^{shreg_q, par_q}) begin
                        parity_err_d = 1'b1;
                    end else if (full_int && !rd_en) begin
                        overflow_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A real edge this cycle clears the counter, so the timeout only
        // fires when the line has genuinely gone quiet mid-frame.
        if ((state_q != S_IDLE) && !fall && (tmo_q == TW'(TIMEOUT_CYC - 1))) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            tmo_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q       <= '0;
            fclk_q       <= 1'b0;
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            shreg_q      <= 8'h00;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            filt_q       <= filt_d;
            fclk_q       <= fclk_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    dout_q, dout_d;
    logic          pop;

    always_comb begin
        pop      = rd_en && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // dout is registered: precompute the head after this cycle's
        // push/pop, bypassing the byte being written when it becomes head.
        if (count_d == '0) begin
            dout_d = 8'h00;
        end else if (push && (wr_ptr_q == rd_ptr_d)) begin
            dout_d = shreg_q;
        end else begin
            dout_d = mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= shreg_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= 8'h00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    assign dout       = dout_q;
    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign full       = full_int;
    assign busy       = (state_q != S_IDLE);
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;

    localparam int FL    = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 200;
    localparam int HALF  = 20;
    localparam int GAP   = 40;

    logic       clk = 1'b0;
    logic       reset, ps2d, ps2c, rx_en, rd_en;
    logic [7:0] dout;
    logic       empty, full, busy, parity_err, frame_err, overflow;
    logic [2:0] count;

    ps2_rx_fifo #(.FILTER_LEN(FL), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rx_en(rx_en),
        .rd_en(rd_en), .dout(dout), .empty(empty), .full(full), .count(count),
        .busy(busy), .parity_err(parity_err), .frame_err(frame_err),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Pulse-cycle counters observed on the DUT.
    int par_seen = 0, frm_seen = 0, ovf_seen = 0;
    always @(negedge clk) begin
        if (parity_err) par_seen++;
        if (frame_err)  frm_seen++;
        if (overflow)   ovf_seen++;
    end

    // Reference model: byte queue plus expected pulse counts.
    logic [7:0] q[$];
    int exp_par = 0, exp_frm = 0, exp_ovf = 0;

    function automatic bit odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    task automatic model_frame(input logic [7:0] d, input bit p, input bit stop,
                               input bit en, input bit rd);
        bit good, ovf, do_push;
        good = en && stop && (^{d, p} == 1'b1);
        if (en && !stop)                exp_frm++;
        else if (en && (^{d, p} == 1'b0)) exp_par++;
        ovf = good && (q.size() == DEPTH) && !rd;
        if (ovf) exp_ovf++;
        do_push = good && !ovf;
        if (rd && q.size() > 0) void'(q.pop_front());
        if (do_push) q.push_back(d);
    endtask

    task automatic send_bit(input bit b, input bit glitch, input bit rd_at_fall);
        ps2d = b;
        ps2c = 1'b1;
        if (glitch) begin
            repeat (5) @(negedge clk);
            ps2c = 1'b0;
            repeat (FL - 1) @(negedge clk);
            ps2c = 1'b1;
            repeat (HALF - 5 - (FL - 1)) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2c = 1'b0;
        if (rd_at_fall) begin
            // The edge is taken on the FL-th low sample; have rd_en there.
            repeat (FL - 1) @(negedge clk);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            repeat (HALF - FL) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
    endtask

    // en_mode: 0 = rx_en low for the frame, 1 = high, 2 = high for start bit only
    task automatic send_frame(input logic [7:0] d, input bit p, input bit stop,
                              input int en_mode, input bit rd, input bit glitch);
        rx_en = (en_mode != 0);
        send_bit(1'b0, glitch, 1'b0);
        if (en_mode == 2) rx_en = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(d[i], glitch, 1'b0);
        send_bit(p, glitch, 1'b0);
        send_bit(stop, glitch, rd);
        ps2c = 1'b1;
        ps2d = 1'b1;
        rx_en = 1'b1;
        repeat (GAP) @(negedge clk);
        model_frame(d, p, stop, en_mode != 0, rd);
    endtask

    task automatic do_pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic test_reset();
        reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1; rd_en = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", empty); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else n_pass++;
        n_checks++; if (count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
        n_checks++; if (dout !== 8'h00) $display("FAIL reset_dout got=%h exp=00", dout); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        reset = 1'b0;
        repeat (GAP) @(negedge clk);
        n_checks++;
        if ({parity_err, frame_err, overflow} !== 3'b000 || frm_seen != 0)
            $display("FAIL reset_pulses got=%b frm_seen=%0d exp=000/0", {parity_err, frame_err, overflow}, frm_seen);
        else n_pass++;
        $display("reset: empty=%b count=%0d dout=%h", empty, count, dout);
    endtask

    task automatic test_valid_frame();
        send_frame(8'h1C, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        n_checks++; if (dout !== 8'h1C) $display("FAIL valid_dout got=%h exp=1c", dout); else n_pass++;
        n_checks++; if (count !== 3'd1) $display("FAIL valid_count got=%0d exp=1", count); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL valid_busy got=%b exp=0", busy); else n_pass++;
        n_checks++;
        if (par_seen != exp_par || frm_seen != exp_frm || ovf_seen != exp_ovf)
            $display("FAIL valid_pulses got=%0d/%0d/%0d exp=%0d/%0d/%0d", par_seen, frm_seen, ovf_seen, exp_par, exp_frm, exp_ovf);
        else n_pass++;
        $display("valid frame: dout=%h count=%0d", dout, count);
        do_pop();
        n_checks++; if (empty !== 1'b1) $display("FAIL valid_pop_empty got=%b exp=1", empty); else n_pass++;
    endtask

    task automatic test_errors();
        send_frame(8'h1C, 1'b1, 1'b1, 1, 1'b0, 1'b0);
        n_checks++; if (par_seen != 1) $display("FAIL parity_pulse got=%0d exp=1", par_seen); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL parity_empty got=%b exp=1", empty); else n_pass++;
        $display("bad parity: parity pulses=%0d empty=%b", par_seen, empty);
        send_frame(8'h1C, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        n_checks++; if (frm_seen != 1) $display("FAIL stop_pulse got=%0d exp=1", frm_seen); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL stop_empty got=%b exp=1", empty); else n_pass++;
        $display("bad stop: frame pulses=%0d", frm_seen);
        rx_en = 1'b1;
        send_bit(1'b1, 1'b0, 1'b0);
        n_checks++; if (busy !== 1'b0) $display("FAIL start1_busy got=%b exp=0", busy); else n_pass++;
        ps2c = 1'b1;
        repeat (GAP) @(negedge clk);
        exp_frm++;
        n_checks++; if (frm_seen != 2) $display("FAIL start1_pulse got=%0d exp=2", frm_seen); else n_pass++;
        $display("bad start: frame pulses=%0d busy=%b", frm_seen, busy);
    endtask

    task automatic test_fifo_full();
        logic [7:0] exp_b;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), odd_par(8'(i)), 1'b1, 1, 1'b0, 1'b0);
            if (i == 4) begin
                n_checks++; if (full !== 1'b1) $display("FAIL full_after4 got=%b exp=1", full); else n_pass++;
            end
            $display("fill frame %0d: count=%0d full=%b", i, count, full);
        end
        n_checks++; if (ovf_seen != 1) $display("FAIL overflow_pulse got=%0d exp=1", ovf_seen); else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            n_checks++; if (dout !== 8'(i)) $display("FAIL pop_order got=%h exp=%h", dout, 8'(i)); else n_pass++;
            $display("pop: dout=%h", dout);
            do_pop();
        end
        n_checks++; if (empty !== 1'b1) $display("FAIL pop_empty got=%b exp=1", empty); else n_pass++;
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), odd_par(8'h10 + 8'(i)), 1'b1, 1, 1'b0, 1'b0);
        send_frame(8'h33, odd_par(8'h33), 1'b1, 1, 1'b1, 1'b0);
        n_checks++; if (count !== 3'd4) $display("FAIL fullrd_count got=%0d exp=4", count); else n_pass++;
        n_checks++; if (ovf_seen != 1) $display("FAIL fullrd_overflow got=%0d exp=1", ovf_seen); else n_pass++;
        $display("full+read push 33: count=%0d", count);
        while (q.size() > 0) begin
            exp_b = q[0];
            n_checks++; if (dout !== exp_b) $display("FAIL fullrd_pop got=%h exp=%h", dout, exp_b); else n_pass++;
            $display("pop: dout=%h", dout);
            do_pop();
        end
        n_checks++; if (exp_b !== 8'h33 || empty !== 1'b1) $display("FAIL fullrd_last got=%h/%b exp=33/1", exp_b, empty); else n_pass++;
    endtask

    task automatic test_timeout();
        rx_en = 1'b1;
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0);
        n_checks++; if (busy !== 1'b1) $display("FAIL timeout_busy_mid got=%b exp=1", busy); else n_pass++;
        ps2c = 1'b1;
        repeat (TMO + 30) @(negedge clk);
        exp_frm++;
        n_checks++; if (frm_seen != exp_frm) $display("FAIL timeout_pulse got=%0d exp=%0d", frm_seen, exp_frm); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL timeout_busy got=%b exp=0", busy); else n_pass++;
        $display("timeout: frame pulses=%0d busy=%b", frm_seen, busy);
        send_frame(8'hF0, 1'b1, 1'b1, 1, 1'b0, 1'b0);
        n_checks++; if (dout !== 8'hF0 || count !== 3'd1) $display("FAIL after_timeout got=%h/%0d exp=f0/1", dout, count); else n_pass++;
        $display("after timeout: dout=%h", dout);
        do_pop();
    endtask

    task automatic test_glitch_and_enable();
        rx_en = 1'b1; ps2d = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ps2c = 1'b0; repeat (FL - 1) @(negedge clk);
            ps2c = 1'b1; repeat (FL + 2) @(negedge clk);
        end
        n_checks++; if (busy !== 1'b0 || frm_seen != exp_frm) $display("FAIL glitch_idle got=%b/%0d exp=0/%0d", busy, frm_seen, exp_frm); else n_pass++;
        send_frame(8'hA5, odd_par(8'hA5), 1'b1, 1, 1'b0, 1'b1);
        n_checks++; if (dout !== 8'hA5 || count !== 3'd1) $display("FAIL glitch_frame got=%h/%0d exp=a5/1", dout, count); else n_pass++;
        $display("glitched frame: dout=%h", dout);
        do_pop();
        send_frame(8'h42, odd_par(8'h42), 1'b1, 0, 1'b0, 1'b0);
        n_checks++; if (empty !== 1'b1 || busy !== 1'b0) $display("FAIL rxen_off got=%b/%b exp=1/0", empty, busy); else n_pass++;
        send_frame(8'h7E, odd_par(8'h7E), 1'b1, 2, 1'b0, 1'b0);
        n_checks++; if (dout !== 8'h7E) $display("FAIL rxen_midframe got=%h exp=7e", dout); else n_pass++;
        $display("rx_en cases: dout=%h count=%0d", dout, count);
    endtask

    task automatic test_reset_mid();
        int p0, f0, o0;
        rx_en = 1'b1;
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0, 1'b0);
        p0 = par_seen; f0 = frm_seen; o0 = ovf_seen;
        reset = 1'b1; ps2c = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        q.delete();
        repeat (GAP) @(negedge clk);
        n_checks++; if (empty !== 1'b1 || busy !== 1'b0) $display("FAIL rstmid_state got=%b/%b exp=1/0", empty, busy); else n_pass++;
        n_checks++;
        if (par_seen != p0 || frm_seen != f0 || ovf_seen != o0)
            $display("FAIL rstmid_pulses got=%0d/%0d/%0d exp=%0d/%0d/%0d", par_seen, frm_seen, ovf_seen, p0, f0, o0);
        else n_pass++;
        send_frame(8'h5A, odd_par(8'h5A), 1'b1, 1, 1'b0, 1'b0);
        n_checks++; if (dout !== 8'h5A || count !== 3'd1) $display("FAIL rstmid_next got=%h/%0d exp=5a/1", dout, count); else n_pass++;
        $display("reset mid-frame: next dout=%h", dout);
        do_pop();
    endtask

    task automatic test_random();
        logic [7:0] d, exp_head;
        int mode, en_mode;
        bit p, stop, rd, gl;
        for (int n = 0; n < 25; n++) begin
            d = 8'($urandom);
            mode = $urandom_range(0, 9);
            p = odd_par(d) ^ (mode == 0);
            stop = (mode != 1);
            en_mode = (mode == 2) ? 0 : (mode == 3) ? 2 : 1;
            rd = ($urandom_range(0, 3) == 0);
            gl = 1'($urandom_range(0, 1));
            send_frame(d, p, stop, en_mode, rd, gl);
            exp_head = (q.size() > 0) ? q[0] : 8'h00;
            n_checks++;
            if (count !== 3'(q.size()) || dout !== exp_head || busy !== 1'b0 ||
                full !== (q.size() == DEPTH) || empty !== (q.size() == 0))
                $display("FAIL rand_state n=%0d got=%0d/%h/%b exp=%0d/%h/0", n, count, dout, busy, q.size(), exp_head);
            else n_pass++;
            n_checks++;
            if (par_seen != exp_par || frm_seen != exp_frm || ovf_seen != exp_ovf)
                $display("FAIL rand_pulses n=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", n, par_seen, frm_seen, ovf_seen, exp_par, exp_frm, exp_ovf);
            else n_pass++;
            $display("rand %0d: data=%h mode=%0d rd=%0b count=%0d dout=%h", n, d, mode, rd, count, dout);
            if ($urandom_range(0, 2) == 0 && q.size() > 0) begin
                n_checks++; if (dout !== q[0]) $display("FAIL rand_pop got=%h exp=%h", dout, q[0]); else n_pass++;
                do_pop();
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_valid_frame();
        test_errors();
        test_fifo_full();
        test_timeout();
        test_glitch_and_enable();
        while (q.size() > 0) do_pop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

PS/2 device-to-host receiver with a configurable clock-glitch filter, full frame checking, an inactivity timeout and an output FIFO. It replaces the bare byte receiver in the keyboard path: it decodes 11-bit frames into bytes and buffers them for the scan-code decoder. Frames are checked for start bit, odd parity and stop bit, and bad or stalled frames are reported instead of delivered.

## Interface
Parameters:
- FILTER_LEN, 8: number of consecutive equal `ps2c` samples needed to change the filtered clock; legal range 2..16.
- FIFO_DEPTH, 4: number of byte entries in the FIFO; must be a power of 2, at least 2.
- TIMEOUT_CYC, 50000: number of `clk` cycles without a filtered falling edge, while mid-frame, before the frame is aborted.

Ports:
- clk in 1: system clock; single clock domain.
- reset in 1: synchronous, active-high reset.
- ps2d in 1: PS/2 data line; asynchronous.
- ps2c in 1: PS/2 clock line; asynchronous.
- rx_en in 1: permits a new frame to start; sampled only in IDLE.
- rd_en in 1: pops the FIFO head; ignored when `empty`=1.
- dout out 8: FIFO head, first-word fall-through; 8'h00 when empty.
- empty out 1: FIFO holds no entries.
- full out 1: FIFO holds FIFO_DEPTH entries.
- count out $clog2(FIFO_DEPTH)+1: number of entries in the FIFO.
- busy out 1: FSM is not in IDLE.
- parity_err out 1: registered 1-cycle pulse; a frame failed the odd-parity check.
- frame_err out 1: registered 1-cycle pulse; bad start bit, bad stop bit, or timeout.
- overflow out 1: registered 1-cycle pulse; a valid byte was dropped because the FIFO was full.

## Operation
- Filter: FILTER_LEN-bit shift register; `ps2c` enters at the MSB.
  - Filtered clock `fclk` is set to 1 when the register is all ones, set to 0 when it is all zeros, otherwise held.
  - `fall` = `fclk_reg & ~fclk_next`; `ps2d` is sampled on the same clock edge.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall & rx_en`:
    - `ps2d`=0: clear the bit counter, go to DATA.
    - `ps2d`=1: pulse `frame_err`, stay in IDLE.
  - DATA: on each `fall`, shift in LSB-first (`b <= {ps2d, b[7:1]}`). After the 8th bit, go to PARITY.
  - PARITY: on `fall`, latch `ps2d` as the parity bit, go to STOP.
  - STOP: on `fall`, go to IDLE and check the frame in this priority order:
    - `ps2d`=0: pulse `frame_err`.
    - else XOR of (8 data bits, parity bit) = 0: pulse `parity_err`.
    - else if the FIFO is full and `rd_en`=0: pulse `overflow`, drop the byte.
    - else push the byte.
- Timeout: the counter is cleared in IDLE and on every `fall`, and increments otherwise. When it reaches TIMEOUT_CYC-1 outside IDLE: go to IDLE, pulse `frame_err`, discard the partial byte.
- `rx_en` deasserted mid-frame does not abort the frame; it only gates the start of the next one.
- FIFO: circular buffer with wrapping read and write pointers; pointer wrap is at FIFO_DEPTH.
  - Push and pop in the same cycle:
    - when full: both succeed, `count` is unchanged.
    - when empty: the pop is ignored, the push succeeds.
  - `full` = (`count` == FIFO_DEPTH); `empty` = (`count` == 0).
- Reset (synchronous):
  - filter register 0, `fclk` 0, FSM to IDLE, timeout counter 0.
  - FIFO cleared: `empty`=1, `full`=0, `count`=0, `dout`=8'h00.
  - `busy`, `parity_err`, `frame_err`, `overflow` all 0.
  - Reset asserted mid-frame aborts the frame with no error pulse.

## Timing
- Edge detection: a falling `ps2c` is recognised on the FILTER_LEN-th consecutive low sample (`fall` is asserted in that cycle). Low pulses shorter than FILTER_LEN cycles are ignored.
- Delivery: the push occurs on the clock edge where STOP sees `fall`. On the following cycle `empty`=0, `count` is incremented and `dout` is valid.
- Error pulses: asserted for exactly 1 cycle, on the cycle after the edge that detects the error.
- Pop: `rd_en`=1 with `empty`=0 advances `dout` to the next entry on the next cycle.
- Throughput: limited only by the PS/2 bit rate. IDLE accepts a new start bit on the first `fall` after STOP.

## Test plan
- Valid frame 0x1C (bits 0, 00111000, parity 0, stop 1) -> `dout`=8'h1C, `count`=1, no error pulses, `busy` returns to 0.
- Frame 0x1C sent with parity bit 1 -> one `parity_err` pulse, FIFO stays empty. Separately, stop bit 0 -> one `frame_err` pulse. Start bit 1 -> one `frame_err` pulse, `busy` stays 0.
- FIFO_DEPTH=4; send frames 0x01..0x05 with no reads -> `full` after the 4th frame, `overflow` pulse on the 5th. Four pops return 01, 02, 03, 04, then `empty`=1.
- FIFO full and a valid byte 0x33 arrives in the same cycle as `rd_en`=1 -> no `overflow`, `count` stays 4, 0x33 is read last.
- Start bit plus 3 data bits, then `ps2c` held high for more than TIMEOUT_CYC cycles -> one `frame_err` pulse, `busy`=0. A following frame 0xF0 (parity 1) is received correctly.
- Glitch and control cases:
  - `ps2c` low glitches of FILTER_LEN-1 cycles -> no bit is taken.
  - `rx_en`=0 at the start bit -> frame ignored.
  - `reset` pulsed mid-frame -> FIFO empty, no error pulses, and the next frame decodes correctly.
